// File: rtl/dispatch_multi_pkg.sv
// ----------------------------------------------------------------------------
// dispatch_multi_pkg
//   Shared types and default constants for the dispatch stage.
//   - default geometry constants (the struct field widths are sized from them,
//     so dispatch_multi must be built with matching parameter values)
//   - controlStruct / dispatchStruct : renamed instruction coming from rename
//   - rsEntry                        : dispatched reservation-station entry
//   - regReqStruct / regRespStruct   : register-file read request / data
//   - fu_mem_code / is_mem_op        : FU encoding helpers (memory FU = NUM_ALU)
// ----------------------------------------------------------------------------
package dispatch_multi_pkg;

    localparam int DEF_WIDTH      = 2;
    localparam int DEF_ROB_DEPTH  = 16;
    localparam int DEF_NUM_ALU    = 2;
    localparam int DEF_PHYS_REGS  = 64;
    localparam int DEF_WAKE_PORTS = 2;

    localparam int XLEN      = 32;
    localparam int PREG_W    = $clog2(DEF_PHYS_REGS);
    localparam int ROB_IDX_W = $clog2(DEF_ROB_DEPTH);
    localparam int FU_W      = $clog2(DEF_NUM_ALU + 1);

    typedef struct packed {
        logic       RegWrite;
        logic       ALUSrc;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic [3:0] ALUOp;
    } controlStruct;

    typedef struct packed {
        controlStruct       control;
        logic [PREG_W-1:0]  rd;
        logic [PREG_W-1:0]  rs1;
        logic [PREG_W-1:0]  rs2;
        logic [XLEN-1:0]    imm;
        logic [XLEN-1:0]    pc;
    } dispatchStruct;

    typedef struct packed {
        logic                 valid;
        controlStruct         control;
        logic [ROB_IDX_W-1:0] robNum;
        logic [FU_W-1:0]      fu;
        logic [PREG_W-1:0]    rd;
        logic [PREG_W-1:0]    rs1;
        logic [PREG_W-1:0]    rs2;
        logic                 src1rdy;
        logic                 src2rdy;
        logic [XLEN-1:0]      src1val;
        logic [XLEN-1:0]      src2val;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc;
    } rsEntry;

    typedef struct packed {
        logic [PREG_W-1:0] rs1;
        logic [PREG_W-1:0] rs2;
    } regReqStruct;

    typedef struct packed {
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
    } regRespStruct;

    // Memory operations always go to the single FU placed after the ALUs.
    function automatic logic [FU_W-1:0] fu_mem_code(input int num_alu);
        return FU_W'(num_alu);
    endfunction

    function automatic logic is_mem_op(input controlStruct c);
        return c.MemRead | c.MemWrite | c.MemtoReg;
    endfunction

endpackage

// File: rtl/dispatch_scoreboard.sv
// ----------------------------------------------------------------------------
// dispatch_scoreboard
//   Busy bit per physical register. Dispatch sets bits, completion broadcasts
//   clear them; a set and clear on the same register in one cycle leaves it
//   busy. p0 never reads busy.
//   Optional feature macro: DISPATCH_WAKE_BYPASS_EN -- a same-cycle wake on a
//   read register reports it not busy.
// Ports:
//   clk, reset      : clock, synchronous active-low reset (clears all bits)
//   set_en/set_preg : WIDTH set ports
//   clr_en/clr_preg : WAKE_PORTS clear ports
//   rd_preg/rd_busy : 2*WIDTH read ports (lane i uses 2i for rs1, 2i+1 for rs2)
// ----------------------------------------------------------------------------
module dispatch_scoreboard
    import dispatch_multi_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int WAKE_PORTS = DEF_WAKE_PORTS,
    parameter int PHYS_REGS  = DEF_PHYS_REGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      set_en,
    input  logic [PREG_W-1:0]     set_preg [WIDTH],
    input  logic [WAKE_PORTS-1:0] clr_en,
    input  logic [PREG_W-1:0]     clr_preg [WAKE_PORTS],
    input  logic [PREG_W-1:0]     rd_preg  [2*WIDTH],
    output logic [2*WIDTH-1:0]    rd_busy
);

    logic [PHYS_REGS-1:0] busy;
    logic [PHYS_REGS-1:0] busy_next;

    // Clears are applied first so that a same-cycle set overrides them.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < WAKE_PORTS; k++) begin
            if (clr_en[k]) busy_next[clr_preg[k]] = 1'b0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (set_en[i]) busy_next[set_preg[i]] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_comb begin
        for (int r = 0; r < 2*WIDTH; r++) begin
            rd_busy[r] = busy[rd_preg[r]] && (rd_preg[r] != '0);
`ifdef DISPATCH_WAKE_BYPASS_EN
            for (int k = 0; k < WAKE_PORTS; k++) begin
                if (clr_en[k] && (clr_preg[k] == rd_preg[r])) rd_busy[r] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: rtl/dispatch_multi.sv
// ----------------------------------------------------------------------------
// dispatch_multi
//   N-wide all-or-nothing dispatch between rename and the RS/ROB. Allocates
//   ROB slots from a wrapping tail with a free counter, tracks register
//   readiness through dispatch_scoreboard, and assigns ALU lanes round-robin
//   while memory lanes go to FU NUM_ALU. Dispatch is combinational; state
//   changes on the rising edge where the group fires.
//   Optional feature macro: DISPATCH_WAKE_BYPASS_EN (same-cycle wake bypass,
//   implemented inside dispatch_scoreboard).
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   in_valid, in_inst   : contiguous valid lanes and their renamed instructions
//   in_ready            : group accepted (rs_ready and enough ROB slots)
//   rs_ready            : RS can take WIDTH entries
//   rs_line             : dispatched entries, zero when the group does not fire
//   reg_request/response: combinational register-file read
//   retire_cnt          : ROB entries freed this cycle
//   wake_valid/wake_preg: completion broadcasts clearing busy bits
//   rob_tail, rob_free  : next ROB index and free-slot count
// ----------------------------------------------------------------------------
module dispatch_multi
    import dispatch_multi_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ROB_DEPTH  = DEF_ROB_DEPTH,
    parameter int NUM_ALU    = DEF_NUM_ALU,
    parameter int PHYS_REGS  = DEF_PHYS_REGS,
    parameter int WAKE_PORTS = DEF_WAKE_PORTS,
    localparam int CNT_W     = $clog2(WIDTH + 1),
    localparam int RIDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_valid,
    input  dispatchStruct         in_inst      [WIDTH],
    output logic                  in_ready,
    input  logic                  rs_ready,
    output rsEntry                rs_line      [WIDTH],
    output regReqStruct           reg_request  [WIDTH],
    input  regRespStruct          reg_response [WIDTH],
    input  logic [CNT_W-1:0]      retire_cnt,
    input  logic [WAKE_PORTS-1:0] wake_valid,
    input  logic [PREG_W-1:0]     wake_preg    [WAKE_PORTS],
    output logic [RIDX_W-1:0]     rob_tail,
    output logic [RIDX_W:0]       rob_free
);

    logic [CNT_W-1:0]    n_req;
    logic [CNT_W-1:0]    alu_cnt;
    logic                slots_ok;
    logic                fire;
    logic [FU_W-1:0]     rr_ptr;
    logic [FU_W-1:0]     rr_next;
    logic [FU_W-1:0]     lane_fu [WIDTH];
    logic [WIDTH-1:0]    dep1;
    logic [WIDTH-1:0]    dep2;
    logic [WIDTH-1:0]    src1rdy;
    logic [WIDTH-1:0]    src2rdy;
    logic [WIDTH-1:0]    set_en;
    logic [PREG_W-1:0]   set_preg [WIDTH];
    logic [PREG_W-1:0]   rd_preg  [2*WIDTH];
    logic [2*WIDTH-1:0]  rd_busy;
    logic [RIDX_W+1:0]   free_sum;
    logic [RIDX_W:0]     free_next;

    always_comb begin
        n_req = '0;
        for (int i = 0; i < WIDTH; i++) n_req = n_req + CNT_W'(in_valid[i]);
    end

    // While reset is held the stage reports ready purely from rs_ready but
    // never fires, so nothing is allocated on a reset edge.
    assign slots_ok = rob_free >= (RIDX_W+1)'(n_req);
    assign in_ready = rs_ready && (!reset || slots_ok);
    assign fire     = reset && rs_ready && slots_ok && (n_req != '0);

    // ALU lanes are numbered among themselves for the round-robin offset.
    always_comb begin
        alu_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (is_mem_op(in_inst[i].control)) begin
                lane_fu[i] = fu_mem_code(NUM_ALU);
            end else begin
                lane_fu[i] = FU_W'((int'(rr_ptr) + int'(alu_cnt)) % NUM_ALU);
                if (in_valid[i]) alu_cnt = alu_cnt + CNT_W'(1);
            end
        end
        rr_next = FU_W'((int'(rr_ptr) + int'(alu_cnt)) % NUM_ALU);
    end

    // Intra-group RAW: an earlier lane writing this lane's source.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            dep1[i] = 1'b0;
            dep2[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (in_valid[j] && in_inst[j].control.RegWrite && (in_inst[j].rd != '0)) begin
                    if (in_inst[j].rd == in_inst[i].rs1) dep1[i] = 1'b1;
                    if (in_inst[j].rd == in_inst[i].rs2) dep2[i] = 1'b1;
                end
            end
            rd_preg[2*i]   = in_inst[i].rs1;
            rd_preg[2*i+1] = in_inst[i].rs2;
            src1rdy[i] = (in_inst[i].rs1 == '0) || (!rd_busy[2*i] && !dep1[i]);
            src2rdy[i] = in_inst[i].control.ALUSrc || (in_inst[i].rs2 == '0)
                         || (!rd_busy[2*i+1] && !dep2[i]);
            set_en[i]   = fire && in_valid[i] && in_inst[i].control.RegWrite
                          && (in_inst[i].rd != '0);
            set_preg[i] = in_inst[i].rd;
        end
    end

    dispatch_scoreboard #(
        .WIDTH      (WIDTH),
        .WAKE_PORTS (WAKE_PORTS),
        .PHYS_REGS  (PHYS_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_preg (set_preg),
        .clr_en   (wake_valid),
        .clr_preg (wake_preg),
        .rd_preg  (rd_preg),
        .rd_busy  (rd_busy)
    );

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rs_line[i]     = '0;
            reg_request[i] = '0;
            if (fire && in_valid[i]) begin
                reg_request[i].rs1 = in_inst[i].rs1;
                reg_request[i].rs2 = in_inst[i].rs2;
                rs_line[i].valid   = 1'b1;
                rs_line[i].control = in_inst[i].control;
                rs_line[i].robNum  = ROB_IDX_W'(rob_tail + RIDX_W'(i));
                rs_line[i].fu      = lane_fu[i];
                rs_line[i].rd      = in_inst[i].rd;
                rs_line[i].rs1     = in_inst[i].rs1;
                rs_line[i].rs2     = in_inst[i].rs2;
                rs_line[i].src1rdy = src1rdy[i];
                rs_line[i].src2rdy = src2rdy[i];
                rs_line[i].src1val = reg_response[i].data1;
                rs_line[i].src2val = reg_response[i].data2;
                rs_line[i].imm     = in_inst[i].imm;
                rs_line[i].pc      = in_inst[i].pc;
            end
        end
    end

    // Retirements beyond the ROB size would be an upstream bug; clamp.
    always_comb begin
        free_sum = {1'b0, rob_free}
                   - (fire ? (RIDX_W+2)'(n_req) : '0)
                   + (RIDX_W+2)'(retire_cnt);
        free_next = (free_sum > (RIDX_W+2)'(ROB_DEPTH)) ? (RIDX_W+1)'(ROB_DEPTH)
                                                        : free_sum[RIDX_W:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rob_tail <= '0;
            rob_free <= (RIDX_W+1)'(ROB_DEPTH);
            rr_ptr   <= '0;
        end else begin
            if (fire) begin
                rob_tail <= rob_tail + RIDX_W'(n_req);
                rr_ptr   <= rr_next;
            end
            rob_free <= free_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) assert (free_sum <= (RIDX_W+2)'(ROB_DEPTH));
    end

endmodule

// File: tb/tb_dispatch_multi.sv
module tb_dispatch_multi;
    import dispatch_multi_pkg::*;

    logic                clk;
    logic                reset;
    logic [1:0]          in_valid;
    dispatchStruct       in_inst      [2];
    logic                in_ready;
    logic                rs_ready;
    rsEntry              rs_line      [2];
    regReqStruct         reg_request  [2];
    regRespStruct        reg_response [2];
    logic [1:0]          retire_cnt;
    logic [1:0]          wake_valid;
    logic [PREG_W-1:0]   wake_preg    [2];
    logic [3:0]          rob_tail;
    logic [4:0]          rob_free;

    int errors;
    int checks;
    logic byp;

    dispatch_multi #(
        .WIDTH      (2),
        .ROB_DEPTH  (16),
        .NUM_ALU    (2),
        .PHYS_REGS  (64),
        .WAKE_PORTS (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_inst      (in_inst),
        .in_ready     (in_ready),
        .rs_ready     (rs_ready),
        .rs_line      (rs_line),
        .reg_request  (reg_request),
        .reg_response (reg_response),
        .retire_cnt   (retire_cnt),
        .wake_valid   (wake_valid),
        .wake_preg    (wake_preg),
        .rob_tail     (rob_tail),
        .rob_free     (rob_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: value is a fixed base plus the register number.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            reg_response[i].data1 = 32'hA000 + 32'(reg_request[i].rs1);
            reg_response[i].data2 = 32'hB000 + 32'(reg_request[i].rs2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic dispatchStruct mk(input logic rw, input logic alusrc, input logic ld,
                                         input logic [5:0] rd, input logic [5:0] rs1,
                                         input logic [5:0] rs2);
        dispatchStruct d;
        d = '0;
        d.control.RegWrite = rw;
        d.control.ALUSrc   = alusrc;
        d.control.MemRead  = ld;
        d.control.MemtoReg = ld;
        d.rd  = rd;
        d.rs1 = rs1;
        d.rs2 = rs2;
        d.imm = 32'h10;
        d.pc  = 32'h100;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid     = 2'b00;
        in_inst[0]   = '0;
        in_inst[1]   = '0;
        rs_ready     = 1'b1;
        retire_cnt   = 2'd0;
        wake_valid   = 2'b00;
        wake_preg[0] = '0;
        wake_preg[1] = '0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
`ifdef DISPATCH_WAKE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        idle();
        reset = 1'b0;
        tick();
        tick();
        chk("rst_tail", 64'(rob_tail), 64'(0));
        chk("rst_free", 64'(rob_free), 64'(16));
        chk("rst_inrdy", 64'(in_ready), 64'(1));
        in_valid   = 2'b11;
        in_inst[0] = mk(1, 0, 0, 5, 1, 2);
        in_inst[1] = mk(1, 0, 0, 6, 3, 4);
        #1;
        chk("rst_line0_v", 64'(rs_line[0].valid), 64'(0));
        chk("rst_line1_v", 64'(rs_line[1].valid), 64'(0));
        chk("rst_req_rs1", 64'(reg_request[0].rs1), 64'(0));
        rs_ready = 1'b0;
        #1;
        chk("rst_inrdy_low", 64'(in_ready), 64'(0));
        tick();
        chk("rst_hold_tail", 64'(rob_tail), 64'(0));
        chk("rst_hold_free", 64'(rob_free), 64'(16));

        // Two ALU ops writing p5/p6.
        reset = 1'b1;
        idle();
        in_valid   = 2'b11;
        in_inst[0] = mk(1, 0, 0, 5, 1, 2);
        in_inst[1] = mk(1, 1, 0, 6, 3, 0);
        #1;
        chk("a_inrdy", 64'(in_ready), 64'(1));
        chk("a_rob0", 64'(rs_line[0].robNum), 64'(0));
        chk("a_rob1", 64'(rs_line[1].robNum), 64'(1));
        chk("a_fu0", 64'(rs_line[0].fu), 64'(0));
        chk("a_fu1", 64'(rs_line[1].fu), 64'(1));
        chk("a_v1", 64'(rs_line[1].valid), 64'(1));
        chk("a_s1rdy0", 64'(rs_line[0].src1rdy), 64'(1));
        chk("a_s1val0", 64'(rs_line[0].src1val), 64'(32'hA001));
        chk("a_s2val0", 64'(rs_line[0].src2val), 64'(32'hB002));
        chk("a_s2rdy1", 64'(rs_line[1].src2rdy), 64'(1));
        chk("a_req1", 64'(reg_request[1].rs1), 64'(3));
        tick();
        chk("a_tail", 64'(rob_tail), 64'(2));
        chk("a_free", 64'(rob_free), 64'(14));

        // Readers of p5/p6 plus an intra-group dependency on p7.
        in_inst[0] = mk(1, 0, 0, 7, 5, 6);
        in_inst[1] = mk(1, 0, 0, 8, 7, 0);
        #1;
        chk("b_s1rdy0", 64'(rs_line[0].src1rdy), 64'(0));
        chk("b_s2rdy0", 64'(rs_line[0].src2rdy), 64'(0));
        chk("b_s1rdy1", 64'(rs_line[1].src1rdy), 64'(0));
        chk("b_s2rdy1", 64'(rs_line[1].src2rdy), 64'(1));
        chk("b_rob0", 64'(rs_line[0].robNum), 64'(2));
        chk("b_fu0", 64'(rs_line[0].fu), 64'(0));
        tick();
        chk("b_tail", 64'(rob_tail), 64'(4));
        chk("b_free", 64'(rob_free), 64'(12));

        // Wake p7 while a reader of p7 dispatches.
        in_valid     = 2'b01;
        in_inst[0]   = mk(0, 0, 0, 0, 7, 0);
        in_inst[1]   = '0;
        wake_valid   = 2'b01;
        wake_preg[0] = 6'd7;
        #1;
        chk("c_s1rdy0", 64'(rs_line[0].src1rdy), 64'(byp));
        chk("c_fu0", 64'(rs_line[0].fu), 64'(0));
        chk("c_rob0", 64'(rs_line[0].robNum), 64'(4));
        chk("c_v1", 64'(rs_line[1].valid), 64'(0));
        tick();
        chk("c_tail", 64'(rob_tail), 64'(5));
        chk("c_free", 64'(rob_free), 64'(11));

        // Load + ALU with rr_ptr = 1.
        wake_valid = 2'b00;
        in_valid   = 2'b11;
        in_inst[0] = mk(1, 1, 1, 10, 7, 0);
        in_inst[1] = mk(1, 0, 0, 11, 10, 12);
        #1;
        chk("d_s1rdy0", 64'(rs_line[0].src1rdy), 64'(1));
        chk("d_s2rdy0", 64'(rs_line[0].src2rdy), 64'(1));
        chk("d_fu0", 64'(rs_line[0].fu), 64'(2));
        chk("d_fu1", 64'(rs_line[1].fu), 64'(1));
        chk("d_s1rdy1", 64'(rs_line[1].src1rdy), 64'(0));
        chk("d_s2rdy1", 64'(rs_line[1].src2rdy), 64'(1));
        chk("d_rob1", 64'(rs_line[1].robNum), 64'(6));
        tick();
        chk("d_tail", 64'(rob_tail), 64'(7));
        chk("d_free", 64'(rob_free), 64'(9));

        // Set p9 and wake p9 in the same cycle.
        in_valid     = 2'b01;
        in_inst[0]   = mk(1, 1, 0, 9, 0, 0);
        in_inst[1]   = '0;
        wake_valid   = 2'b10;
        wake_preg[1] = 6'd9;
        #1;
        chk("e_fu0", 64'(rs_line[0].fu), 64'(0));
        chk("e_s1rdy0", 64'(rs_line[0].src1rdy), 64'(1));
        tick();
        chk("e_tail", 64'(rob_tail), 64'(8));
        wake_valid = 2'b00;
        in_inst[0] = mk(0, 0, 0, 0, 9, 5);
        #1;
        chk("f_p9_busy", 64'(rs_line[0].src1rdy), 64'(0));
        chk("f_p5_busy", 64'(rs_line[0].src2rdy), 64'(0));
        chk("f_fu0", 64'(rs_line[0].fu), 64'(1));
        tick();
        chk("f_tail", 64'(rob_tail), 64'(9));
        chk("f_free", 64'(rob_free), 64'(7));

        // Fill the ROB down to one free slot.
        in_valid   = 2'b11;
        in_inst[0] = mk(0, 1, 0, 0, 0, 0);
        in_inst[1] = mk(0, 1, 0, 0, 0, 0);
        for (int g = 0; g < 3; g++) begin
            #1;
            chk("fill_rob0", 64'(rs_line[0].robNum), 64'(9 + 2*g));
            tick();
            chk("fill_free", 64'(rob_free), 64'(5 - 2*g));
        end
        chk("fill_tail", 64'(rob_tail), 64'(15));
        #1;
        chk("stall_inrdy", 64'(in_ready), 64'(0));
        chk("stall_v0", 64'(rs_line[0].valid), 64'(0));
        chk("stall_rob0", 64'(rs_line[0].robNum), 64'(0));
        chk("stall_req", 64'(reg_request[0].rs1), 64'(0));
        tick();
        chk("stall_tail", 64'(rob_tail), 64'(15));
        chk("stall_free", 64'(rob_free), 64'(1));
        retire_cnt = 2'd1;
        #1;
        chk("stall_ret_inrdy", 64'(in_ready), 64'(0));
        tick();
        chk("stall_ret_free", 64'(rob_free), 64'(2));
        chk("stall_ret_tail", 64'(rob_tail), 64'(15));
        #1;
        chk("wrap_inrdy", 64'(in_ready), 64'(1));
        chk("wrap_rob0", 64'(rs_line[0].robNum), 64'(15));
        chk("wrap_rob1", 64'(rs_line[1].robNum), 64'(0));
        tick();
        chk("wrap_tail", 64'(rob_tail), 64'(1));
        chk("wrap_free", 64'(rob_free), 64'(1));

        // Exact fit, then full ROB with retirement in the same cycle.
        retire_cnt = 2'd0;
        in_valid   = 2'b01;
        in_inst[0] = mk(0, 0, 0, 0, 10, 0);
        in_inst[1] = '0;
        #1;
        chk("fit_inrdy", 64'(in_ready), 64'(1));
        chk("fit_p10_busy", 64'(rs_line[0].src1rdy), 64'(0));
        tick();
        chk("fit_free", 64'(rob_free), 64'(0));
        chk("fit_tail", 64'(rob_tail), 64'(2));
        retire_cnt = 2'd2;
        #1;
        chk("full_inrdy", 64'(in_ready), 64'(0));
        chk("full_v0", 64'(rs_line[0].valid), 64'(0));
        tick();
        chk("full_free", 64'(rob_free), 64'(2));
        chk("full_tail", 64'(rob_tail), 64'(2));

        // Empty group and RS back-pressure.
        retire_cnt = 2'd0;
        in_valid   = 2'b00;
        #1;
        chk("empty_inrdy", 64'(in_ready), 64'(1));
        chk("empty_v0", 64'(rs_line[0].valid), 64'(0));
        tick();
        chk("empty_tail", 64'(rob_tail), 64'(2));
        in_valid = 2'b01;
        rs_ready = 1'b0;
        #1;
        chk("rsbp_inrdy", 64'(in_ready), 64'(0));
        tick();
        chk("rsbp_tail", 64'(rob_tail), 64'(2));
        chk("rsbp_free", 64'(rob_free), 64'(2));

        // Reset asserted with a valid group in flight.
        rs_ready   = 1'b1;
        in_valid   = 2'b11;
        in_inst[0] = mk(1, 0, 0, 20, 0, 0);
        in_inst[1] = mk(1, 0, 0, 21, 0, 0);
        reset      = 1'b0;
        #1;
        chk("mid_inrdy", 64'(in_ready), 64'(1));
        chk("mid_v0", 64'(rs_line[0].valid), 64'(0));
        tick();
        chk("mid_tail", 64'(rob_tail), 64'(0));
        chk("mid_free", 64'(rob_free), 64'(16));
        reset      = 1'b1;
        in_valid   = 2'b01;
        in_inst[0] = mk(0, 0, 0, 0, 10, 20);
        in_inst[1] = '0;
        #1;
        chk("post_s1rdy", 64'(rs_line[0].src1rdy), 64'(1));
        chk("post_s2rdy", 64'(rs_line[0].src2rdy), 64'(1));
        chk("post_rob0", 64'(rs_line[0].robNum), 64'(0));
        chk("post_fu0", 64'(rs_line[0].fu), 64'(0));
        tick();
        chk("post_tail", 64'(rob_tail), 64'(1));
        chk("post_free", 64'(rob_free), 64'(15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
